// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with latency-matched pixel output stage.
// Latency: request coordinate to pins is PIX_LATENCY+1 pixel periods for colour, blank, hs and vs.
// Backpressure: none; free-running timing, the colour source must answer every request on time.
// Optional build macro VGA_TEST_PATTERN_EN adds an 8-bar test pattern selectable with tp_sel.
module vga_timing_pipe #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 2,
  parameter int PIX_LATENCY = 1,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic        active_req,
  input  logic [23:0] rgb_in,
  input  logic        tp_sel,
  output logic        frame_start,
  output logic        frame_done,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  // Timing constants, all folded into the 10-bit counter domain.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [3:0] DIV_HALF = 4'(CLK_DIV / 2);

  // One pipeline slot: everything that must stay aligned with the returned colour.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] x;
  } stage_t;

  // Inactive slot: syncs deasserted, blanked, x parked at 0.
  localparam stage_t STAGE_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0, 10'd0};

  logic [3:0]  div_cnt;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        h_wrap;
  logic        v_wrap;
  logic        hs_on;
  logic        vs_on;
  stage_t      raw_s;
  stage_t      del_s;
  logic [23:0] src_rgb;

  // Pixel strobe divider: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= 4'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= 4'd0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  assign pix_en  = (div_cnt == DIV_LAST);
  assign vga_clk = (div_cnt >= DIV_HALF);

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Raster counters: h advances every pixel, v on each line wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_cnt <= 10'd0;
        if (v_wrap) begin
          v_cnt <= 10'd0;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign x_pixel     = h_cnt;
  assign y_pixel     = v_cnt;
  assign active_req  = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
  assign frame_start = pix_en && h_wrap && v_wrap;
  assign frame_done  = pix_en && (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);

  assign hs_on = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_on = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  // Raw decode of the current request coordinate.
  always_comb begin
    raw_s     = STAGE_IDLE;
    raw_s.hs  = hs_on ? SYNC_POL : ~SYNC_POL;
    raw_s.vs  = vs_on ? SYNC_POL : ~SYNC_POL;
    raw_s.act = active_req;
    raw_s.x   = h_cnt;
  end

  // Delay line matching the colour source latency; zero latency is a wire.
  generate
    if (PIX_LATENCY == 0) begin : g_nodly
      assign del_s = raw_s;
    end else begin : g_dly
      stage_t dly [PIX_LATENCY];

      // Shift one slot per pixel period.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIX_LATENCY; i++) begin
            dly[i] <= STAGE_IDLE;
          end
        end else if (pix_en) begin
          dly[0] <= raw_s;
          for (int i = 1; i < PIX_LATENCY; i++) begin
            dly[i] <= dly[i-1];
          end
        end
      end

      assign del_s = dly[PIX_LATENCY-1];
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  // Eight equal vertical bars, indexed by threshold compares on the delayed x.
  function automatic logic [23:0] bar_colour(input logic [9:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= 10'(k * BAR_W)) begin
        idx = 3'(k);
      end
    end
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  assign src_rgb = tp_sel ? bar_colour(del_s.x) : rgb_in;
`else
  // Without the pattern generator the delayed x and tp_sel have no consumer.
  logic unused_pattern;
  assign unused_pattern = ^{tp_sel, del_s.x};
  assign src_rgb = rgb_in;
`endif

  // Pin register: colour is forced to black whenever the slot is blanked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'd0;
      vga_g       <= 8'd0;
      vga_b       <= 8'd0;
    end else if (pix_en) begin
      vga_hs      <= del_s.hs;
      vga_vs      <= del_s.vs;
      vga_blank_n <= del_s.act;
      if (del_s.act) begin
        {vga_r, vga_g, vga_b} <= src_rgb;
      end else begin
        {vga_r, vga_g, vga_b} <= 24'd0;
      end
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: doc/vga_timing_pipe.md
# vga_timing_pipe

Parametrised VGA timing and pixel-pipeline block, the successor to the fixed 640x480 driver wrapper. It derives a pixel strobe from the system clock and generates sync and blanking for any timing set. It issues pixel request coordinates to a colour source (game or framebuffer) with configurable read latency, then delays sync, blank and active flags so they stay aligned with the returned colour. It sits between `game` and the board VGA pins.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal porch and sync widths, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical porch and sync widths, in lines
- `CLK_DIV`, 2: clk cycles per pixel; legal range 2..16
- `PIX_LATENCY`, 1: colour source latency in pixel periods; legal range 0..7
- `SYNC_POL`, 0: active sync level (0 = active-low)
- `clk`  in  1  system clock (CLOCK_50)
- `rst`  in  1  asynchronous, active-low reset
- `pix_en`  out  1  one-clk pixel strobe
- `x_pixel`, `y_pixel`  out  10 each  request coordinate (raw h/v counters)
- `active_req`  out  1  request coordinate lies inside the active area
- `rgb_in`  in  24  {R,G,B}, valid PIX_LATENCY pixel periods after its coordinate
- `tp_sel`  in  1  test-pattern select
- `frame_start`, `frame_done`  out  1 each  one-clk event pulses
- `vga_clk`, `vga_hs`, `vga_vs`, `vga_blank_n`, `vga_sync_n`  out  1 each  DAC/monitor controls
- `vga_r`, `vga_g`, `vga_b`  out  8 each  registered colour

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (div_cnt == CLK_DIV-1).
  - `vga_clk` = (div_cnt >= CLK_DIV/2).
- Counters advance only on `pix_en`.
  - `h_cnt` wraps at H_TOTAL-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1.
  - `v_cnt` increments on h wrap and wraps at V_TOTAL-1.
  - Both totals must be ≤1024; 10-bit unsigned arithmetic.
- `x_pixel` = h_cnt and `y_pixel` = v_cnt. `active_req` is a combinational decode: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Raw sync decode: hs asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs uses the same rule on v_cnt. Asserted level = SYNC_POL.
- Alignment pipeline:
  - hs, vs, active and the 10-bit x pass through PIX_LATENCY stages, shifting on `pix_en`.
  - A final output register, also on `pix_en`, drives the pins.
  - On that register: `vga_blank_n` = delayed active; rgb = delayed active ? source : 0.
- `vga_sync_n` is constant 0.
- `frame_start` pulses on the `pix_en` cycle where the counters wrap to (0,0).
- `frame_done` pulses on the `pix_en` cycle where the request coordinate is (H_ACTIVE-1, V_ACTIVE-1). This marks the game-update window.
- Reset mid-frame clears all state immediately. Timing restarts at (0,0) with no partial-line recovery.

## Timing
- Reset values:
  - div_cnt, h_cnt, v_cnt, x_pixel, y_pixel = 0; `active_req` = 1 (decode of 0,0).
  - pix_en, frame_start, frame_done, vga_blank_n = 0; rgb = 0.
  - vga_hs, vga_vs at deasserted level (!SYNC_POL); all pipeline stages hold inactive values.
- First `pix_en` occurs CLK_DIV cycles after reset release.
- Coordinate to pins latency: PIX_LATENCY+1 pixel periods, identical for colour, blank, hs and vs.
- `rgb_in` is sampled on the `pix_en` cycle only.
- Default parameters: line = 800 pixels = 1600 clk; frame = 525 lines = 840000 clk.

## Configuration
- `VGA_TEST_PATTERN_EN` defined: when `tp_sel`=1, the colour source is 8 vertical bars, each H_ACTIVE/8 wide.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bars are computed from the delayed x, so they are aligned and `rgb_in` is ignored.
- Not defined: `tp_sel` is ignored and `rgb_in` is always the source. No bar logic is synthesised.

## Test plan
- Divider: defaults, release reset → `pix_en` high every 2nd clk starting at clk 2. `vga_clk` high when div_cnt=1.
- Line and frame: run one frame → `frame_start` pulse period 840000 clk; `frame_done` once per frame at request (639,479). hs pulses every 1600 clk, each 192 clk wide, starting PIX_LATENCY+1 pixels after request h_cnt=656.
- Latency alignment: PIX_LATENCY=3, model returns rgb_in = {x[7:0], y[7:0], 8'hA5} → pins show that value exactly 4 pixels after the coordinate. `vga_blank_n` rises on the same pixel; rgb=0 outside active.
- Blanking gate: rgb_in = 24'hFFFFFF constant → vga_r/g/b = 0 during every porch and sync interval.
- Reset mid-frame: assert rst at v_cnt=200 → all outputs take reset values asynchronously. After release, counters restart at (0,0) and the next `frame_start` comes 840000 clk later.
- Pattern (macro defined, tp_sel=1): active pixel 85 → FFFF00 (yellow); pixel 639 → 000000. With tp_sel=0 the output follows rgb_in.
